// File: rtl/load_dispatch.sv
// Job dispatcher: routes each accepted job to the least-used worker channel and pulses ce/id back to the counter stage.
// Optional feature: define LOAD_DISPATCH_SKIP_BUSY_EN to redirect jobs away from a target channel that is not ready at acceptance.
module load_dispatch #(
    parameter int W_D        = 32,
    parameter int SETTLE_CYC = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W_D-1:0] in_data,
    input  logic [1:0]     min_id,
    output logic [3:0]     out_valid,
    input  logic [3:0]     out_ready,
    output logic [W_D-1:0] out_data,
    output logic           ce,
    output logic [1:0]     id,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);

    state_t         state_q, state_d;
    logic [1:0]     target_q, target_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           in_ready_q, in_ready_d;
    logic [3:0]     out_valid_q, out_valid_d;
    logic [W_D-1:0] out_data_q, out_data_d;
    logic           ce_q, ce_d;
    logic [1:0]     id_q, id_d;
    logic           busy_q, busy_d;
    logic [1:0]     target_sel;

    always_comb begin
        target_sel = min_id;
`ifdef LOAD_DISPATCH_SKIP_BUSY_EN
        // Descending scan so the lowest ready index wins.
        if (!out_ready[min_id]) begin
            for (int i = 3; i >= 0; i--) begin
                if (out_ready[i]) begin
                    target_sel = 2'(i);
                end
            end
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ce_d        = 1'b0;
        id_d        = id_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
                if (in_valid && in_ready_q) begin
                    out_data_d  = in_data;
                    target_d    = target_sel;
                    out_valid_d = 4'b0001 << target_sel;
                    in_ready_d  = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (out_ready[target_q]) begin
                    out_valid_d = 4'b0000;
                    ce_d        = 1'b1;
                    id_d        = target_q;
                    cnt_d       = SETTLE_LOAD;
                    state_d     = SETTLE;
                end
            end
            SETTLE: begin
                // The ce cycle itself counts as the first settle cycle.
                if (cnt_q == 4'd0) begin
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                out_valid_d = 4'b0000;
                in_ready_d  = 1'b0;
                busy_d      = 1'b0;
                cnt_d       = 4'd0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            target_q    <= 2'b00;
            cnt_q       <= 4'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 4'b0000;
            out_data_q  <= '0;
            ce_q        <= 1'b0;
            id_q        <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ce_q        <= ce_d;
            id_q        <= id_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ce        = ce_q;
    assign id        = id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_load_dispatch.sv
// Directed bench for load_dispatch: one instance at SETTLE_CYC=2 (with a usage-counter model for the closed loop)
// and one at SETTLE_CYC=0 for the back-to-back throughput case.
module tb_load_dispatch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [1:0]  min_id;
   logic [1:0]  minIdDrv = 2'd0;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready = 4'b0000;
   logic [31:0] out_data;
   logic        ce;
   logic [1:0]  id;
   logic        busy;

   logic        in_valid_z = 1'b0;
   logic        in_ready_z;
   logic [31:0] in_data_z = '0;
   logic [1:0]  min_id_z = 2'd2;
   logic [3:0]  out_valid_z;
   logic [3:0]  out_ready_z = 4'b1111;
   logic [31:0] out_data_z;
   logic        ce_z;
   logic [1:0]  id_z;
   logic        busy_z;

   logic             useModel = 1'b0;
   logic [3:0][7:0]  useCnt;
   logic [1:0]       modelMinQ;

   int testsRun = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

   load_dispatch #(.W_D(32), .SETTLE_CYC(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .min_id(min_id),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .ce(ce), .id(id), .busy(busy)
   );

   load_dispatch #(.W_D(32), .SETTLE_CYC(0)) dutZero (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_z), .in_ready(in_ready_z), .in_data(in_data_z),
      .min_id(min_id_z),
      .out_valid(out_valid_z), .out_ready(out_ready_z), .out_data(out_data_z),
      .ce(ce_z), .id(id_z), .busy(busy_z)
   );

   // Lowest index among the smallest usage counts.
   function automatic logic [1:0] argMin(input logic [3:0][7:0] cnt);
      logic [1:0] best;
      best = 2'd0;
      for (int i = 1; i < 4; i++) begin
         if (cnt[i] < cnt[best]) best = 2'(i);
      end
      return best;
   endfunction

   // Counter/minimum-select stage model: counts on ce, min register one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         useCnt    <= '0;
         modelMinQ <= 2'd0;
      end else begin
         if (ce) useCnt[id] <= useCnt[id] + 8'd1;
         modelMinQ <= argMin(useCnt);
      end
   end

   assign min_id = useModel ? modelMinQ : minIdDrv;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ticks until in_ready is high; n is the number of ticks taken, 99 on timeout.
   task automatic waitReady(output int n);
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (!in_ready) n = 99;
   endtask

   task automatic applyStimulus(input logic [1:0] mid, input logic [31:0] data, input logic [3:0] rdy);
      minIdDrv  = mid;
      in_data   = data;
      out_ready = rdy;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
   endtask

   initial begin
      int n;
      int chanCount [4];
      int cyc;
      int lastHs;
      int gaps;

      // Reset state
      tick();
      tick();
      checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_data", 64'(out_data), 64'd0);
      checkOutput("rst_ce", 64'(ce), 64'd0);
      checkOutput("rst_id", 64'(id), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      tick();
      checkOutput("rst_release_ready", 64'(in_ready), 64'd1);

      // Basic dispatch
      applyStimulus(2'd2, 32'hA5A5_0001, 4'b1111);
      checkOutput("basic_out_valid", 64'(out_valid), 64'b0100);
      checkOutput("basic_out_data", 64'(out_data), 64'hA5A5_0001);
      checkOutput("basic_busy", 64'(busy), 64'd1);
      checkOutput("basic_in_ready_low", 64'(in_ready), 64'd0);
      checkOutput("basic_no_ce_yet", 64'(ce), 64'd0);
      tick();
      checkOutput("basic_ce", 64'(ce), 64'd1);
      checkOutput("basic_id", 64'(id), 64'd2);
      checkOutput("basic_valid_cleared", 64'(out_valid), 64'd0);
      tick();
      checkOutput("basic_ce_one_cycle", 64'(ce), 64'd0);
      waitReady(n);
      checkOutput("basic_ready_latency", 64'(n), 64'd2);
      checkOutput("basic_busy_idle", 64'(busy), 64'd0);

      // Backpressure on channel 1 while other channels are ready
      applyStimulus(2'd1, 32'h1234_5678, 4'b1101);
      in_data  = 32'hDEAD_BEEF;
      minIdDrv = 2'd3;
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_out_valid", 64'(out_valid), 64'b0010);
         checkOutput("bp_out_data", 64'(out_data), 64'h1234_5678);
         checkOutput("bp_no_ce", 64'(ce), 64'd0);
         tick();
      end
      checkOutput("bp_still_valid", 64'(out_valid), 64'b0010);
      out_ready = 4'b0010;
      tick();
      checkOutput("bp_ce", 64'(ce), 64'd1);
      checkOutput("bp_id", 64'(id), 64'd1);
      checkOutput("bp_valid_cleared", 64'(out_valid), 64'd0);
      waitReady(n);
      checkOutput("bp_ready_latency", 64'(n), 64'd3);

      // Skip-busy target selection
      applyStimulus(2'd3, 32'h0000_5151, 4'b0110);
`ifdef LOAD_DISPATCH_SKIP_BUSY_EN
      checkOutput("skip_out_valid", 64'(out_valid), 64'b0010);
`else
      checkOutput("skip_out_valid", 64'(out_valid), 64'b1000);
`endif
      out_ready = 4'b1111;
      tick();
      checkOutput("skip_ce", 64'(ce), 64'd1);
`ifdef LOAD_DISPATCH_SKIP_BUSY_EN
      checkOutput("skip_id", 64'(id), 64'd1);
`else
      checkOutput("skip_id", 64'(id), 64'd3);
`endif
      waitReady(n);
      checkOutput("skip_ready", 64'(in_ready), 64'd1);
      applyStimulus(2'd3, 32'h0000_5252, 4'b0000);
      checkOutput("skip_none_out_valid", 64'(out_valid), 64'b1000);
      out_ready = 4'b1111;
      tick();
      checkOutput("skip_none_id", 64'(id), 64'd3);
      waitReady(n);
      checkOutput("skip_none_ready", 64'(in_ready), 64'd1);

      // Reset in the middle of ISSUE
      applyStimulus(2'd0, 32'h0BAD_F00D, 4'b0000);
      checkOutput("rmid_out_valid", 64'(out_valid), 64'b0001);
      tick();
      rst_n = 1'b0;
      #1;
      checkOutput("rmid_out_valid_clr", 64'(out_valid), 64'd0);
      checkOutput("rmid_ce", 64'(ce), 64'd0);
      checkOutput("rmid_busy", 64'(busy), 64'd0);
      checkOutput("rmid_in_ready", 64'(in_ready), 64'd0);
      checkOutput("rmid_out_data", 64'(out_data), 64'd0);
      tick();
      rst_n = 1'b1;
      out_ready = 4'b1111;
      tick();
      checkOutput("rmid_ready_after", 64'(in_ready), 64'd1);
      checkOutput("rmid_no_job", 64'(out_valid), 64'd0);

      // Closed loop with the counter stage model
      useModel = 1'b1;
      foreach (chanCount[c]) chanCount[c] = 0;
      for (int j = 0; j < 8; j++) begin
         waitReady(n);
         checkOutput("cl_ready", 64'(in_ready), 64'd1);
         in_data  = 32'(j);
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         checkOutput("cl_out_valid", 64'(out_valid), 64'(4'b0001 << (j % 4)));
         checkOutput("cl_out_data", 64'(out_data), 64'(j));
         tick();
         checkOutput("cl_ce", 64'(ce), 64'd1);
         checkOutput("cl_id", 64'(id), 64'(j % 4));
         if (ce) chanCount[id]++;
      end
      for (int c = 0; c < 4; c++) checkOutput("cl_chan_count", 64'(chanCount[c]), 64'd2);
      useModel = 1'b0;

      // SETTLE_CYC=0: next acceptance two cycles after each output handshake
      lastHs = -1;
      gaps   = 0;
      in_valid_z = 1'b1;
      for (cyc = 0; cyc < 40; cyc++) begin
         in_data_z = 32'(cyc);
         if (in_ready_z && lastHs >= 0) begin
            checkOutput("s0_gap", 64'(cyc - lastHs), 64'd2);
            lastHs = -1;
            gaps++;
         end
         if ((out_valid_z & out_ready_z) != 4'b0000) lastHs = cyc;
         tick();
      end
      in_valid_z = 1'b0;
      checkOutput("s0_gap_count", 64'(gaps >= 5), 64'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
